// File: rtl/shrg_pkg.sv
// Shared definitions for the Super Hires VRAM writer: region bounds, FIFO entry
// layout, arbiter states and the bus-address decode helpers.
package shrg_pkg;

    localparam logic [15:0] SHR_BASE     = 16'h2000;
    localparam logic [15:0] SHR_LAST     = 16'h9FFF;
    localparam logic [12:0] SCB_WORD     = 13'd8000;
    localparam logic [12:0] PALETTE_WORD = 13'd8064;

    localparam int unsigned WORD_AW = 13;
    localparam int unsigned LANE_W  = 2;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned LANES   = 4;
    localparam int unsigned DATA_W  = LANES * BYTE_W;

    typedef struct packed {
        logic [WORD_AW-1:0] word;
        logic [LANE_W-1:0]  lane;
        logic [BYTE_W-1:0]  data;
    } shrg_fifo_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_RDATA = 2'd2,
        ST_WRITE = 2'd3
    } shrg_state_t;

    function automatic logic shr_in_region(input logic [15:0] addr);
        return (addr >= SHR_BASE) && (addr <= SHR_LAST);
    endfunction

    // Offset from $2000 splits into a 32-bit word index and a little-endian byte lane.
    function automatic shrg_fifo_entry_t shr_make_entry(input logic [15:0] addr,
                                                       input logic [7:0]  data);
        shrg_fifo_entry_t e;
        logic [14:0]      offset;
        offset = 15'(addr - SHR_BASE);
        e.word = offset[14:2];
        e.lane = offset[1:0];
        e.data = data;
        return e;
    endfunction

    function automatic logic [LANES-1:0] shr_lane_be(input logic [LANE_W-1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/shrg_vram_bram.sv
// Single-port word RAM with per-byte write enables and a registered read port,
// written so synthesis maps it onto block RAM. Contents are never reset.
module shrg_vram_bram
    import shrg_pkg::*;
#(
    parameter int unsigned WORDS = 8192,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic [LANES-1:0]  i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [WORDS];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/shrg_vram_writer.sv
// Snoops bank $E1 SHR writes into a small FIFO, drains them byte-wise into the
// VRAM, and serves VGC word fetches with priority over the write drain.
module shrg_vram_writer
    import shrg_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RAM_WORDS  = 8192
) (
    input  logic                clk_logic,
    input  logic                system_reset_n,
    input  logic                wr_valid_i,
    input  logic [15:0]         wr_addr_i,
    input  logic [7:0]          wr_data_i,
    input  logic                wr_bank_e1_i,
    input  logic                vgc_rd_i,
    input  logic [WORD_AW-1:0]  vgc_address_i,
    output logic [DATA_W-1:0]   vgc_data_o,
    output logic [2:0]          fifo_level_o,
    output logic                overflow_o
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W  = 3;
    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

    shrg_state_t       r_state;
    shrg_state_t       w_state_nxt;

    shrg_fifo_entry_t  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_overflow;

    logic              r_rd_q;
    logic              r_rd_pend;
    logic [WORD_AW-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_vgc_data;

    logic              w_accept;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_rd_edge;
    logic              w_rd_req;
    shrg_fifo_entry_t  w_new_entry;
    shrg_fifo_entry_t  w_head;

    logic              w_ram_en;
    logic [LANES-1:0]  w_ram_we;
    logic [RAM_AW-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

    // Bus-side capture
    assign w_accept    = wr_valid_i & wr_bank_e1_i & shr_in_region(wr_addr_i);
    assign w_new_entry = shr_make_entry(wr_addr_i, wr_data_i);
    assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty     = (r_level == '0);
    assign w_push      = w_accept & ~w_full;
    assign w_pop       = (r_state == ST_WRITE) & ~w_empty;
    assign w_head      = r_fifo[r_rd_ptr];

    // Read request: rising edge of the level strobe, or one parked while busy
    assign w_rd_edge = vgc_rd_i & ~r_rd_q;
    assign w_rd_req  = w_rd_edge | r_rd_pend;

    always_ff @(posedge clk_logic) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_new_entry;
        end
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_accept & w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_rd_q    <= 1'b0;
            r_rd_pend <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_rd_q <= vgc_rd_i;
            if (w_rd_edge) begin
                r_rd_addr <= vgc_address_i;
            end
            // IDLE always consumes a request by moving to READ
            if (r_state == ST_IDLE) begin
                r_rd_pend <= 1'b0;
            end else if (w_rd_edge) begin
                r_rd_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_req) begin
                    w_state_nxt = ST_READ;
                end else if (!w_empty) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_READ:  w_state_nxt = ST_RDATA;
            ST_RDATA: w_state_nxt = ST_IDLE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = '0;
        w_ram_addr  = RAM_AW'(r_rd_addr);
        w_ram_wdata = {LANES{w_head.data}};
        if (r_state == ST_READ) begin
            w_ram_en = 1'b1;
        end else if (w_pop) begin
            w_ram_en   = 1'b1;
            w_ram_we   = shr_lane_be(w_head.lane);
            w_ram_addr = RAM_AW'(w_head.word);
        end
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_vgc_data <= '0;
        end else if (r_state == ST_RDATA) begin
            r_vgc_data <= w_ram_rdata;
        end
    end

    shrg_vram_bram #(
        .WORDS (RAM_WORDS),
        .AW    (RAM_AW)
    ) u_bram (
        .i_clk   (clk_logic),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign vgc_data_o   = r_vgc_data;
    assign fifo_level_o = r_level;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_shrg_vram_writer.sv
// Scoreboard bench for shrg_vram_writer: stimulus queues expected outputs with
// a due cycle; a negedge monitor compares them as they come due.
`timescale 1ns/1ps
module tb_shrg_vram_writer;

    localparam int K_DATA  = 0;
    localparam int K_LEVEL = 1;
    localparam int K_OVF   = 2;

    logic        clk_logic = 1'b0;
    logic        system_reset_n = 1'b0;
    logic        wr_valid_i = 1'b0;
    logic [15:0] wr_addr_i = 16'h0;
    logic [7:0]  wr_data_i = 8'h0;
    logic        wr_bank_e1_i = 1'b1;
    logic        vgc_rd_i = 1'b0;
    logic [12:0] vgc_address_i = 13'h0;
    logic [31:0] vgc_data_o;
    logic [2:0]  fifo_level_o;
    logic        overflow_o;

    typedef struct {
        int          kind;
        int          due;
        logic [31:0] val;
        string       name;
    } chk_t;

    chk_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_vgc = 32'h0;

    shrg_vram_writer #(
        .FIFO_DEPTH (4),
        .RAM_WORDS  (8192)
    ) dut (
        .clk_logic      (clk_logic),
        .system_reset_n (system_reset_n),
        .wr_valid_i     (wr_valid_i),
        .wr_addr_i      (wr_addr_i),
        .wr_data_i      (wr_data_i),
        .wr_bank_e1_i   (wr_bank_e1_i),
        .vgc_rd_i       (vgc_rd_i),
        .vgc_address_i  (vgc_address_i),
        .vgc_data_o     (vgc_data_o),
        .fifo_level_o   (fifo_level_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_logic = ~clk_logic;

    always @(posedge clk_logic) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d checks pending", sb.size());
        $fatal(1, "watchdog");
    end

    always @(negedge clk_logic) begin : monitor
        logic [31:0] act;
        int          i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= cyc) begin
                case (sb[i].kind)
                    K_DATA:  act = vgc_data_o;
                    K_LEVEL: act = {29'd0, fifo_level_o};
                    default: act = {31'd0, overflow_o};
                endcase
                checks++;
                if (act !== sb[i].val || sb[i].due != cyc) begin
                    errors++;
                    $display("FAIL %s: actual %h required %h (cycle %0d, due %0d)",
                             sb[i].name, act, sb[i].val, cyc, sb[i].due);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    function automatic void expect_at(input int kind, input int due,
                                      input logic [31:0] val, input string name);
        chk_t c;
        c.kind = kind;
        c.due  = due;
        c.val  = val;
        c.name = name;
        sb.push_back(c);
    endfunction

    task automatic drive(input logic rd, input logic [12:0] ra, input logic wv,
                         input logic [15:0] wa, input logic [7:0] wd, input logic bank);
        @(negedge clk_logic);
        vgc_rd_i      = rd;
        vgc_address_i = ra;
        wr_valid_i    = wv;
        wr_addr_i     = wa;
        wr_data_i     = wd;
        wr_bank_e1_i  = bank;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 13'd0, 1'b0, 16'h0, 8'h0, 1'b1);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic bank);
        drive(1'b0, 13'd0, 1'b1, a, d, bank);
    endtask

    // Raise the strobe for two cycles; lat = cycles from edge cycle to data.
    task automatic read_word(input logic [12:0] a, input logic [31:0] exp,
                             input int lat, input string name);
        drive(1'b1, a, 1'b0, 16'h0, 8'h0, 1'b1);
        expect_at(K_DATA, cyc + lat - 1, exp_vgc, {name, "_hold"});
        expect_at(K_DATA, cyc + lat, exp, name);
        exp_vgc = exp;
        drive(1'b1, a, 1'b0, 16'h0, 8'h0, 1'b1);
        drive(1'b0, 13'd0, 1'b0, 16'h0, 8'h0, 1'b1);
        idle(lat);
    endtask

    initial begin
        int c;
        expect_at(K_DATA,  1, 32'h0, "rst_data");
        expect_at(K_LEVEL, 1, 32'h0, "rst_level");
        expect_at(K_OVF,   1, 32'h0, "rst_ovf");
        idle(2);
        system_reset_n = 1'b1;
        idle(2);

        // Byte packing, little-endian lanes
        wr(16'h2000, 8'h11, 1'b1);
        wr(16'h2001, 8'h22, 1'b1);
        wr(16'h2002, 8'h33, 1'b1);
        wr(16'h2003, 8'h44, 1'b1);
        idle(12);
        read_word(13'd0, 32'h44332211, 3, "pack_word0");

        // Region decode and boundaries
        wr(16'h9D04, 8'h00, 1'b1);
        wr(16'h9D05, 8'hAA, 1'b1);
        wr(16'h9D06, 8'h00, 1'b1);
        wr(16'h9D07, 8'h00, 1'b1);
        idle(12);
        read_word(13'd8001, 32'h0000AA00, 3, "region_word8001");
        wr(16'h1FFF, 8'h55, 1'b1);
        expect_at(K_LEVEL, cyc + 1, 32'd0, "below_region_level");
        wr(16'hA000, 8'h55, 1'b1);
        expect_at(K_LEVEL, cyc + 1, 32'd0, "above_region_level");
        wr(16'h9FFF, 8'h12, 1'b1);
        expect_at(K_LEVEL, cyc + 1, 32'd1, "last_addr_level");
        idle(8);

        // Bank gating
        wr(16'h3000, 8'h01, 1'b1);
        wr(16'h3001, 8'h02, 1'b1);
        wr(16'h3002, 8'h03, 1'b1);
        wr(16'h3003, 8'h04, 1'b1);
        idle(12);
        wr(16'h3000, 8'h5A, 1'b0);
        expect_at(K_LEVEL, cyc + 1, 32'd0, "bank_gate_level");
        idle(8);
        read_word(13'd1024, 32'h04030201, 3, "bank_gate_word1024");

        // Read and ready FIFO entry in the same cycle: read wins, returns old data
        wr(16'h2000, 8'h99, 1'b1);
        expect_at(K_LEVEL, cyc + 4, 32'd1, "coll_level_during_read");
        read_word(13'd0, 32'h44332211, 3, "coll_read_first");
        idle(6);
        read_word(13'd0, 32'h44332299, 3, "coll_write_after");

        // Edge landing on a WRITE cycle
        wr(16'h2001, 8'h66, 1'b1);
        idle(1);
        read_word(13'd0, 32'h44336699, 4, "edge_in_write");

        // Same byte twice: arrival order
        wr(16'h2003, 8'h77, 1'b1);
        wr(16'h2003, 8'h88, 1'b1);
        idle(12);
        read_word(13'd0, 32'h88336699, 3, "same_byte_order");

        // Overflow under continuous reads
        wr(16'h4004, 8'hEE, 1'b1);
        wr(16'h4005, 8'hEE, 1'b1);
        wr(16'h4006, 8'hEE, 1'b1);
        wr(16'h4007, 8'hEE, 1'b1);
        idle(12);
        c = 0;
        for (int k = 0; k < 12; k++) begin
            if (k >= 1 && k <= 5) begin
                drive(k % 3 != 2, 13'd0, 1'b1, 16'h4000 + 16'(k - 1), 8'(k), 1'b1);
            end else begin
                drive(k % 3 != 2, 13'd0, 1'b0, 16'h0, 8'h0, 1'b1);
            end
            if (k == 0) begin
                c = cyc;
                expect_at(K_LEVEL, c + 4,  32'd3, "ovf_level3");
                expect_at(K_LEVEL, c + 5,  32'd4, "ovf_level4");
                expect_at(K_OVF,   c + 5,  32'd0, "ovf_not_yet");
                expect_at(K_LEVEL, c + 6,  32'd4, "ovf_level_sat");
                expect_at(K_OVF,   c + 6,  32'd1, "ovf_set");
                expect_at(K_LEVEL, c + 11, 32'd4, "ovf_reads_starve_writes");
            end
        end
        exp_vgc = 32'h88336699;
        idle(12);
        expect_at(K_LEVEL, cyc + 1, 32'd0, "ovf_drained");
        expect_at(K_OVF,   cyc + 1, 32'd1, "ovf_sticky");
        idle(1);
        read_word(13'd2048, 32'h04030201, 3, "ovf_first4_landed");
        read_word(13'd2049, 32'hEEEEEEEE, 3, "ovf_fifth_dropped");

        // Reset with entries queued and a read in READ
        wr(16'h2190, 8'hA1, 1'b1);
        wr(16'h2191, 8'hB2, 1'b1);
        wr(16'h2192, 8'hC3, 1'b1);
        wr(16'h2193, 8'hD4, 1'b1);
        idle(12);
        for (int k = 0; k < 4; k++) begin
            if (k >= 1) begin
                drive(k % 3 != 2, 13'd0, 1'b1, 16'h2190 + 16'(k - 1), 8'(k * 17), 1'b1);
            end else begin
                drive(1'b1, 13'd0, 1'b0, 16'h0, 8'h0, 1'b1);
            end
        end
        @(posedge clk_logic);
        #1;
        system_reset_n = 1'b0;
        vgc_rd_i   = 1'b0;
        wr_valid_i = 1'b0;
        expect_at(K_DATA,  cyc, 32'h0, "midrst_data");
        expect_at(K_LEVEL, cyc, 32'h0, "midrst_level");
        expect_at(K_OVF,   cyc, 32'h0, "midrst_ovf");
        exp_vgc = 32'h0;
        idle(2);
        system_reset_n = 1'b1;
        idle(12);
        checks++;
        if (fifo_level_o !== 3'd0) begin
            errors++;
            $display("FAIL post_rst_level_direct: actual %h required 0", fifo_level_o);
        end
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_ovf_direct: actual %b required 0", overflow_o);
        end
        checks++;
        if (vgc_data_o !== 32'h0) begin
            errors++;
            $display("FAIL post_rst_data_direct: actual %h required 0", vgc_data_o);
        end
        expect_at(K_LEVEL, cyc + 1, 32'd0, "post_rst_level");
        idle(1);
        read_word(13'd100, 32'hD4C3B2A1, 3, "post_rst_no_stale_write");

        idle(4);
        for (int t = 0; t < 50 && sb.size() != 0; t++) begin
            @(negedge clk_logic);
        end
        while (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: never compared, required %h by cycle %0d",
                     sb[0].name, sb[0].val, sb[0].due);
            void'(sb.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shrg_vram_writer.md
# shrg_vram_writer

Responder side of the Super Hires video memory port. Captures Apple II bus byte writes that land in the SHR region (bank $E1, $2000–$9FFF), packs them into a byte-enabled 8192×32 block RAM, and services the video graphics controller's 13-bit word-address read strobes. It sits between the bus snooper and the VGC and replaces any external memory path for SHR fetches. It guarantees read data well inside the VGC's 24-logic-clock window.

## Interface
- FIFO_DEPTH, 4: pending bus-write entries, power of two.
- RAM_WORDS, 8192: RAM depth in 32-bit words.
- clk_logic  in  1  logic clock; 2× the pixel clock.
- system_reset_n  in  1  reset; asynchronous, active-low.
- wr_valid_i  in  1  one-cycle pulse: bus write observed.
- wr_addr_i  in  16  bus address.
- wr_data_i  in  8  bus data.
- wr_bank_e1_i  in  1  the write targets bank $E1, or shadowing to it is enabled.
- vgc_rd_i  in  1  VGC fetch strobe; level, high ≥2 clk_logic.
- vgc_address_i  in  13  VGC word address.
- vgc_data_o  out  32  read data; held until the next read completes.
- fifo_level_o  out  3  pending entries, 0..FIFO_DEPTH.
- overflow_o  out  1  sticky: a write was dropped because the FIFO was full.

## Operation
- Accept a write when wr_valid_i & wr_bank_e1_i & 16'h2000 ≤ wr_addr_i ≤ 16'h9FFF.
- Offset = wr_addr_i − 16'h2000, 15 bits. Word = offset[14:2]. Lane = offset[1:0], little-endian: lane 0 = bits 7:0.
- Consequences: pixel data occupies words 0..7999, scanline controls start at word 8000, palettes start at word 8064.
- An accepted write pushes {word, lane, data} into the FIFO.
  - If the FIFO is full: the entry is discarded and overflow_o is set. Only reset clears overflow_o.
- Read request: a rising edge of vgc_rd_i, detected against a registered copy of the strobe. vgc_address_i is latched on the detection cycle.
- Arbiter FSM with states IDLE, READ, RDATA, WRITE:
  - IDLE → READ when a read request is pending. Otherwise IDLE → WRITE when the FIFO is not empty.
  - READ: drive the RAM read. → RDATA.
  - RDATA: register RAM output into vgc_data_o. → IDLE.
  - WRITE: pop one entry and perform a single-byte write with a 4-bit one-hot byte enable. → IDLE.
- A read request and a non-empty FIFO in the same cycle: the read wins.
- A read edge that arrives during WRITE, READ or RDATA is held in a 1-bit pending flag. It is never lost.
- FIFO push and pop in the same cycle: the level is unchanged.
- There is no forwarding from the FIFO to reads: a read returns RAM contents only, so queued writes are not yet visible.
- Writes to the same byte are applied in arrival order.
- RAM contents are not cleared by reset.

## Timing
- Reset values: vgc_data_o = 0, fifo_level_o = 0, overflow_o = 0, FSM = IDLE, pending flag = 0, edge register = 0.
- Read latency when the FSM is IDLE: edge detected at cycle N, READ at N+1, vgc_data_o valid at N+3.
- Worst-case read latency, when the edge lands on a WRITE cycle: 4 cycles. This is far under the 24-cycle budget.
- Write drain: one entry per IDLE→WRITE pair. Each entry costs 2 cycles.
  - Sustained bus writes (one per ~28 cycles) never fill the FIFO.
- fifo_level_o and overflow_o are registered and update the cycle after a push or pop.
- Reset asserted mid-operation:
  - The FIFO is emptied immediately and the in-flight read is abandoned.
  - vgc_data_o returns to 0.
  - A RAM write in its issue cycle may or may not land.

## Structure
- Shared package shrg_pkg holds:
  - SHR_BASE = 16'h2000, SHR_LAST = 16'h9FFF, SCB_WORD = 13'd8000, PALETTE_WORD = 13'd8064.
  - The FIFO entry typedef {word[12:0], lane[1:0], data[7:0]}.
  - The arbiter state enum.
- One sub-module, shrg_vram_bram: single-port 8192×32 RAM with 4 byte-write enables and registered output, inferable as block RAM.
- The FIFO and the arbiter live inline in shrg_vram_writer.

## Test plan
- Byte packing:
  - Stimulus: write $11, $22, $33, $44 to $E1:2000..2003, drain, then pulse vgc_rd_i with address 0.
  - Expected: vgc_data_o = 32'h44332211 exactly 3 cycles after the detected edge.
- Region decode:
  - Stimulus: write $AA to $E1:9D05, drain, read word 8001. Then write $55 to $E1:1FFF and to $E1:A000.
  - Expected: word 8001 returns byte $AA in lane 1. The $55 writes do not change fifo_level_o.
- Bank gating:
  - Stimulus: write $5A to $E1:3000 with wr_bank_e1_i = 0.
  - Expected: fifo_level_o stays 0, and word 1024 is unchanged.
- Collision:
  - Stimulus: raise vgc_rd_i in the same cycle a FIFO entry is ready.
  - Expected: the read completes first with data at N+3, and the write lands afterward.
  - Stimulus: an edge that arrives during WRITE.
  - Expected: data at N+4.
- Overflow:
  - Stimulus: hold the FSM busy with back-to-back reads and push 5 writes.
  - Expected: fifo_level_o saturates at 4, overflow_o = 1, the 5th byte is absent, and the first 4 bytes land in order.
- Reset:
  - Stimulus: assert system_reset_n low with 3 entries queued and a read in READ.
  - Expected: all outputs are 0 within the same cycle, and after release the queued bytes never appear in RAM.
